tank_game_sequencer: RTL and testbench
======================================

Name: tank_game_sequencer

Overview:
- Top-level game-flow controller for the two-tank game.
- Owns the MENU → PLAY → ROUND_END → GAME_OVER sequence and tracks per-player round scores.
- Issues round-restart pulses to the tank, bullet and wall modules.
- Drives the screen-select and winner signals the color mapper uses to choose between the playfield and the game-over/player-wins overlay. This replaces the mapper's internal sticky death flags.

Parameters:
- WIN_SCORE, 3: rounds needed to win the match (1..7).
- ROUND_DELAY_FRAMES, 120: frames held in ROUND_END before the next round or game over (1..255).
- ROUND_TIMEOUT_FRAMES, 1800: max frames per round; used only with the optional feature (1..4095).

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- frame_clk  in  1  VGA vertical sync, Clk domain; a frame tick is its rising edge
- start_key  in  1  start/restart key level
- tank1_alive  in  1  tank 1 alive
- tank2_alive  in  1  tank 2 alive
- play_en  out  1  1 while game objects may move or fire
- round_reset  out  1  one-cycle pulse that reinitialises tanks, bullets and walls
- game_state  out  2  00 MENU, 01 PLAY, 10 ROUND_END, 11 GAME_OVER
- p1_score  out  3  player 1 rounds won
- p2_score  out  3  player 2 rounds won
- winner  out  2  00 none, 01 P1, 10 P2
- show_gameover  out  1  1 in GAME_OVER; color mapper overlay select

Behaviour:
- Reset (async assert, sync deassert by Clk):
  - game_state=MENU; scores=0; winner=00.
  - play_en=0, round_reset=0, show_gameover=0.
  - Frame counter=0; edge registers=0; armed=0.
- Edge detection:
  - frame_tick = frame_clk & ~frame_clk_q.
  - start_press = start_key & ~start_key_q.
  - Both are registered one cycle; a key held through reset does not produce a press.
- MENU:
  - On start_press: clear scores and winner, pulse round_reset, go PLAY, all in the same edge.
- PLAY:
  - play_en=1.
  - armed clears on entry and sets on the first frame_tick in PLAY. Deaths are ignored while armed=0, which masks stale alive values during round_reset.
  - When armed, death rules:
    - ~tank1_alive & tank2_alive: p2_score+1.
    - tank1_alive & ~tank2_alive: p1_score+1.
    - Both dead in the same cycle: draw, no score change.
  - On any death: go ROUND_END and clear the frame counter. Scores saturate at WIN_SCORE.
- ROUND_END:
  - play_en=0; the counter increments on each frame_tick.
  - When counter == ROUND_DELAY_FRAMES-1 and frame_tick:
    - If p1_score==WIN_SCORE: winner=01, go GAME_OVER.
    - Else if p2_score==WIN_SCORE: winner=10, go GAME_OVER.
    - Else: pulse round_reset, go PLAY.
  - Both scores at WIN_SCORE cannot occur, because only one score increments per round.
- GAME_OVER:
  - show_gameover=1; winner and scores hold.
  - start_press goes to MENU with scores unchanged; they clear on the next start.
- round_reset is exactly one Clk cycle wide and never asserts outside the MENU→PLAY and ROUND_END→PLAY transitions.
- start_press is ignored in PLAY and ROUND_END.
- Reset mid-round returns to MENU immediately; no round_reset pulse is generated.
- All outputs are registered; state changes are visible one cycle after the triggering edge.

Optional Feature:
- Macro: TANK_ROUND_TIMEOUT_EN.
- Defined:
  - A 12-bit PLAY frame counter clears on PLAY entry.
  - If ROUND_TIMEOUT_FRAMES frame_ticks elapse with no death, the round is a draw: go ROUND_END, no score change.
  - A death on the same tick as the timeout takes priority over the timeout.
- Undefined: no timeout counter exists, and a round lasts until a death.

Decomposition:
- Shared package tank_game_pkg:
  - game_state_t enum (MENU, PLAY, ROUND_END, GAME_OVER) with the 2-bit encodings above.
  - winner_t enum.
  - Default constants WIN_SCORE_DEF and ROUND_DELAY_DEF.
- Sub-module edge_pulse: one-cycle rising-edge detector, instantiated for frame_clk and start_key.

Test Plan:
- Reset, then start_press → round_reset high exactly 1 cycle; game_state=01; play_en=1; scores 0/0.
- tank2_alive low before the first frame_tick in PLAY → ignored. After one frame_tick, tank2_alive low → p1_score=1; state=10. After 120 frame_ticks → round_reset pulse; state=01.
- Both alive inputs drop in the same cycle (armed) → scores unchanged; state=10.
- P1 wins 3 rounds → after the third ROUND_END delay: state=11, winner=01, show_gameover=1, p1_score=3. start_press → state=00.
- Reset asserted mid-ROUND_END → outputs take reset values asynchronously with no round_reset pulse; start_key held high through reset deassert → stays in MENU until released and pressed again.
- TANK_ROUND_TIMEOUT_EN with ROUND_TIMEOUT_FRAMES=10 → 10 frame_ticks with no death → state=10, scores unchanged. A death coinciding with the 10th tick → score increments.

Source files
------------

// File: rtl/tank_game_pkg.sv
// Shared types and defaults for the two-tank game-flow controller.
package tank_game_pkg;

  typedef enum logic [1:0] {
    MENU      = 2'b00,
    PLAY      = 2'b01,
    ROUND_END = 2'b10,
    GAME_OVER = 2'b11
  } game_state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_t;

  localparam int WIN_SCORE_DEF     = 3;
  localparam int ROUND_DELAY_DEF   = 120;
  localparam int ROUND_TIMEOUT_DEF = 1800;

  // Scores stop at the match-winning value.
  function automatic logic [2:0] sat_inc(input logic [2:0] v, input logic [2:0] lim);
    return (v >= lim) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/edge_pulse.sv
// Registered one-cycle rising-edge detector. The first sample after reset
// only primes the history, so a level already high at reset release is not an edge.
module edge_pulse (
  input  logic Clk,
  input  logic Reset,
  input  logic sig,
  output logic pulse
);

  logic sig_q;
  logic primed;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sig_q  <= 1'b0;
      primed <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      sig_q  <= sig;
      primed <= 1'b1;
      pulse  <= primed & sig & ~sig_q;
    end
  end

endmodule

// File: rtl/tank_game_sequencer.sv
// Game-flow controller: MENU -> PLAY -> ROUND_END -> GAME_OVER, round scores,
// round restart pulses and overlay select. Optional round timeout: TANK_ROUND_TIMEOUT_EN.
module tank_game_sequencer
  import tank_game_pkg::*;
#(
  parameter int WIN_SCORE            = WIN_SCORE_DEF,
  parameter int ROUND_DELAY_FRAMES   = ROUND_DELAY_DEF,
  parameter int ROUND_TIMEOUT_FRAMES = ROUND_TIMEOUT_DEF
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       start_key,
  input  logic       tank1_alive,
  input  logic       tank2_alive,
  output logic       play_en,
  output logic       round_reset,
  output logic [1:0] game_state,
  output logic [2:0] p1_score,
  output logic [2:0] p2_score,
  output logic [1:0] winner,
  output logic       show_gameover
);

  localparam logic [2:0] WIN        = 3'(WIN_SCORE);
  localparam logic [7:0] DELAY_LAST = 8'(ROUND_DELAY_FRAMES - 1);

  // Asserts at once with Reset, releases two Clk edges after it drops.
  logic [1:0] rst_pipe;
  logic       rst;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) rst_pipe <= 2'b11;
    else       rst_pipe <= {rst_pipe[0], 1'b0};
  end
  assign rst = rst_pipe[1];

  logic frame_tick;
  logic start_press;

  edge_pulse u_frame_edge (.Clk(Clk), .Reset(rst), .sig(frame_clk), .pulse(frame_tick));
  edge_pulse u_start_edge (.Clk(Clk), .Reset(rst), .sig(start_key), .pulse(start_press));

  game_state_t state_q, state_d;
  winner_t     winner_q, winner_d;
  logic [2:0]  p1_q, p1_d, p2_q, p2_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        armed_q, armed_d;
  logic        rr_q, rr_d;
  logic        play_en_q, show_q;
  logic        death;
  logic        timeout_hit;

`ifdef TANK_ROUND_TIMEOUT_EN
  localparam logic [11:0] TO_LAST = 12'(ROUND_TIMEOUT_FRAMES - 1);
  logic [11:0] play_cnt_q;

  // Held at zero outside PLAY, so it always starts a round from zero.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst)                 play_cnt_q <= '0;
    else if (state_q != PLAY) play_cnt_q <= '0;
    else if (frame_tick)     play_cnt_q <= play_cnt_q + 12'd1;
  end
  assign timeout_hit = frame_tick && (play_cnt_q == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // Stale alive levels right after round_reset are masked until the first frame.
  assign death = armed_q & ~(tank1_alive & tank2_alive);

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    cnt_d    = cnt_q;
    armed_d  = armed_q;
    rr_d     = 1'b0;
    unique case (state_q)
      MENU: begin
        if (start_press) begin
          p1_d     = '0;
          p2_d     = '0;
          winner_d = WIN_NONE;
          armed_d  = 1'b0;
          rr_d     = 1'b1;
          state_d  = PLAY;
        end
      end
      PLAY: begin
        if (frame_tick) armed_d = 1'b1;
        if (death || timeout_hit) begin
          if (~tank1_alive & tank2_alive && death)      p2_d = sat_inc(p2_q, WIN);
          else if (tank1_alive & ~tank2_alive && death) p1_d = sat_inc(p1_q, WIN);
          cnt_d   = '0;
          state_d = ROUND_END;
        end
      end
      ROUND_END: begin
        if (frame_tick) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == DELAY_LAST) begin
            if (p1_q == WIN) begin
              winner_d = WIN_P1;
              state_d  = GAME_OVER;
            end else if (p2_q == WIN) begin
              winner_d = WIN_P2;
              state_d  = GAME_OVER;
            end else begin
              armed_d = 1'b0;
              rr_d    = 1'b1;
              state_d = PLAY;
            end
          end
        end
      end
      GAME_OVER: begin
        if (start_press) state_d = MENU;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state_q   <= MENU;
      winner_q  <= WIN_NONE;
      p1_q      <= '0;
      p2_q      <= '0;
      cnt_q     <= '0;
      armed_q   <= 1'b0;
      rr_q      <= 1'b0;
      play_en_q <= 1'b0;
      show_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      rr_q      <= rr_d;
      play_en_q <= (state_d == PLAY);
      show_q    <= (state_d == GAME_OVER);
    end
  end

  assign play_en       = play_en_q;
  assign round_reset   = rr_q;
  assign game_state    = state_q;
  assign p1_score      = p1_q;
  assign p2_score      = p2_q;
  assign winner        = winner_q;
  assign show_gameover = show_q;

endmodule

// File: tb/tb_tank_game_sequencer.sv
// Bench for tank_game_sequencer: event-level game model, directed scenarios
// plus a randomized match.
module tb_tank_game_sequencer;

  localparam int WIN   = 3;
  localparam int DELAY = 120;
  localparam int TO    = 10;

  localparam int S_MENU = 0;
  localparam int S_PLAY = 1;
  localparam int S_RE   = 2;
  localparam int S_GO   = 3;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic       start_key;
  logic       tank1_alive;
  logic       tank2_alive;
  logic       play_en;
  logic       round_reset;
  logic [1:0] game_state;
  logic [2:0] p1_score;
  logic [2:0] p2_score;
  logic [1:0] winner;
  logic       show_gameover;

  int errors = 0;
  int checks = 0;

  // Game model
  int m_state, m_p1, m_p2, m_win, m_cnt, m_pcnt;
  bit m_armed, m_rr;
  int rr_expected = 0;
  int rr_seen     = 0;

  always #5 Clk = ~Clk;

  tank_game_sequencer #(
    .WIN_SCORE(WIN),
    .ROUND_DELAY_FRAMES(DELAY),
    .ROUND_TIMEOUT_FRAMES(TO)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .frame_clk(frame_clk),
    .start_key(start_key),
    .tank1_alive(tank1_alive),
    .tank2_alive(tank2_alive),
    .play_en(play_en),
    .round_reset(round_reset),
    .game_state(game_state),
    .p1_score(p1_score),
    .p2_score(p2_score),
    .winner(winner),
    .show_gameover(show_gameover)
  );

  always @(negedge Clk) if (round_reset === 1'b1) rr_seen++;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  function automatic int min_win(input int v);
    return (v > WIN) ? WIN : v;
  endfunction

  task automatic m_reset();
    m_state = S_MENU; m_p1 = 0; m_p2 = 0; m_win = 0;
    m_cnt = 0; m_pcnt = 0; m_armed = 0; m_rr = 0;
  endtask

  task automatic m_enter_play();
    m_state = S_PLAY; m_armed = 0; m_pcnt = 0; m_rr = 1; rr_expected++;
  endtask

  task automatic m_start();
    if (m_state == S_MENU) begin
      m_p1 = 0; m_p2 = 0; m_win = 0;
      m_enter_play();
    end else if (m_state == S_GO) begin
      m_state = S_MENU;
    end
  endtask

  task automatic m_death(input bit a1, input bit a2);
    if (m_state == S_PLAY && m_armed && !(a1 && a2)) begin
      if (!a1 && a2)      m_p2 = min_win(m_p2 + 1);
      else if (a1 && !a2) m_p1 = min_win(m_p1 + 1);
      m_state = S_RE;
      m_cnt   = 0;
    end
  endtask

  task automatic m_tick();
    if (m_state == S_PLAY) begin
      m_armed = 1;
      m_pcnt++;
`ifdef TANK_ROUND_TIMEOUT_EN
      if (m_pcnt == TO) begin m_state = S_RE; m_cnt = 0; end
`endif
    end else if (m_state == S_RE) begin
      m_cnt++;
      if (m_cnt == DELAY) begin
        if (m_p1 == WIN)      begin m_win = 1; m_state = S_GO; end
        else if (m_p2 == WIN) begin m_win = 2; m_state = S_GO; end
        else m_enter_play();
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/state"}, 8'(game_state), 8'(m_state));
    chk({tag, "/p1"}, 8'(p1_score), 8'(m_p1));
    chk({tag, "/p2"}, 8'(p2_score), 8'(m_p2));
    chk({tag, "/winner"}, 8'(winner), 8'(m_win));
    chk({tag, "/play_en"}, 8'(play_en), 8'(m_state == S_PLAY));
    chk({tag, "/show_go"}, 8'(show_gameover), 8'(m_state == S_GO));
    chk({tag, "/round_reset"}, 8'(round_reset), 8'(m_rr));
    m_rr = 0;
  endtask

  task automatic post_check();
    step(1);
    chk("rr_width", 8'(round_reset), 8'd0);
  endtask

  task automatic press_start(input string tag);
    start_key = 1'b1;
    step(2);
    m_start();
    check_all(tag);
    post_check();
    start_key = 1'b0;
    step(1);
  endtask

  task automatic tick(input string tag);
    frame_clk = 1'b1;
    step(1);
    frame_clk = 1'b0;
    step(1);
    m_tick();
    check_all(tag);
    post_check();
    step($urandom_range(0, 2));
  endtask

  task automatic kill(input string tag, input bit a1, input bit a2);
    tank1_alive = a1;
    tank2_alive = a2;
    step(1);
    m_death(a1, a2);
    check_all(tag);
    post_check();
    tank1_alive = 1'b1;
    tank2_alive = 1'b1;
    step(1);
  endtask

  task automatic finish_round_end(input string tag);
    for (int i = 0; i < 2 * DELAY && m_state == S_RE; i++) tick(tag);
    chk({tag, "/left_re"}, 8'(m_state != S_RE), 8'd1);
  endtask

`ifdef TANK_ROUND_TIMEOUT_EN
  task automatic tick_with_death(input string tag, input bit a1, input bit a2);
    int s;
    frame_clk = 1'b1;
    step(1);
    frame_clk   = 1'b0;
    tank1_alive = a1;
    tank2_alive = a2;
    step(1);
    s = m_state;
    m_death(a1, a2);
    if (m_state == s) m_tick();
    check_all(tag);
    tank1_alive = 1'b1;
    tank2_alive = 1'b1;
    post_check();
  endtask
`endif

  initial begin
    int rounds;
    int pick;
    Reset = 1'b1; frame_clk = 1'b0; start_key = 1'b0;
    tank1_alive = 1'b1; tank2_alive = 1'b1;
    m_reset();
    step(3);
    check_all("reset");
    Reset = 1'b0;
    step(4);
    check_all("after_reset");

    // First round: pre-arm death ignored, then P1 scores.
    press_start("start_menu");
    kill("prearm_kill", 1'b1, 1'b0);
    tick("arm_tick");
    press_start("start_in_play");
    kill("p1_scores", 1'b1, 1'b0);
    finish_round_end("delay1");

    // Draw round.
    tick("arm2");
    kill("draw", 1'b0, 1'b0);
    finish_round_end("delay2");

    // P1 takes two more rounds and the match.
    for (int r = 0; r < 2; r++) begin
      tick("arm_p1");
      kill("p1_win_round", 1'b1, 1'b0);
      finish_round_end("delay_p1");
    end
    check_all("game_over");
    press_start("go_to_menu");
    press_start("restart");

    // Randomized match until someone wins or the round budget runs out.
    rounds = 0;
    while (m_state != S_GO && rounds < 12) begin
      if (m_state == S_PLAY) begin
        if ($urandom_range(0, 1) == 1) kill("rand_prearm", 1'b0, 1'b1);
        tick("rand_arm");
        pick = $urandom_range(0, 4);
        if (pick <= 1)      kill("rand_p1", 1'b1, 1'b0);
        else if (pick <= 3) kill("rand_p2", 1'b0, 1'b1);
        else                kill("rand_draw", 1'b0, 1'b0);
      end
      finish_round_end("rand_delay");
      rounds++;
    end
    if (m_state == S_GO) press_start("rand_go_menu");

    // Reset in ROUND_END with start held through release.
    if (m_state == S_MENU) press_start("pre_reset_start");
    tick("pre_reset_arm");
    kill("pre_reset_p2", 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) tick("re_partial");
    start_key = 1'b1;
    step(2);
    m_start();
    check_all("start_in_re");
    #2;
    Reset = 1'b1;
    #1;
    m_reset();
    check_all("async_reset");
    step(2);
    Reset = 1'b0;
    step(6);
    check_all("held_key");
    start_key = 1'b0;
    step(2);
    check_all("key_released");
    press_start("fresh_start");

`ifdef TANK_ROUND_TIMEOUT_EN
    for (int i = 0; i < TO; i++) tick("timeout_ticks");
    chk("timeout_state", 8'(game_state), 8'(S_RE));
    finish_round_end("timeout_delay");
    for (int i = 0; i < TO - 1; i++) tick("pre_timeout");
    tick_with_death("death_at_timeout", 1'b1, 1'b0);
`endif

    step(2);
    chk("rr_count", 8'(rr_seen), 8'(rr_expected));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
